// File: rtl/serial_adder_arbiter_pkg.sv
// Shared definitions for the two-requester bit-serial adder: FSM state
// encoding and the full-adder carry function.
package serial_adder_arbiter_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_CALC = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/serial_adder_dpath.sv
// Bit-serial adder datapath: operand/sum shift registers, one full-adder
// cell, the carry flop and the bit counter.
module serial_adder_dpath
   import serial_adder_arbiter_pkg::*;
#(
   parameter int p_nbits = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load,
   input  logic               shift,
   input  logic               clear,
   input  logic [p_nbits-1:0] a_in,
   input  logic [p_nbits-1:0] b_in,
   output logic [p_nbits-1:0] sum,
   output logic               cout,
   output logic               last_bit
);

   localparam int CW = $clog2(p_nbits);

   logic [p_nbits-1:0] a_q, a_d;
   logic [p_nbits-1:0] b_q, b_d;
   logic [p_nbits-1:0] sum_q, sum_d;
   logic               carry_q, carry_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               s_bit;

   assign last_bit = (cnt_q == CW'(p_nbits - 1));
   assign s_bit    = a_q[0] ^ b_q[0] ^ carry_q;

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      if (clear) begin
         carry_d = 1'b0;
         cnt_d   = '0;
         sum_d   = '0;
      end
      if (load) begin
         a_d = a_in;
         b_d = b_in;
      end else if (shift) begin
         a_d     = a_q >> 1;
         b_d     = b_q >> 1;
         sum_d   = {s_bit, sum_q[p_nbits-1:1]};
         carry_d = maj3(a_q[0], b_q[0], carry_q);
         // Saturate on the final bit so the counter never wraps.
         if (!last_bit) begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sum  = sum_q;
   assign cout = carry_q;

endmodule

// File: rtl/serial_adder_arbiter.sv
// Round-robin arbiter and sequencing FSM sharing one bit-serial adder between
// two val/rdy requesters; results return tagged with the requester index.
module serial_adder_arbiter
   import serial_adder_arbiter_pkg::*;
#(
   parameter int p_nbits = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               req0_val,
   output logic               req0_rdy,
   input  logic [p_nbits-1:0] req0_a,
   input  logic [p_nbits-1:0] req0_b,
   input  logic               req1_val,
   output logic               req1_rdy,
   input  logic [p_nbits-1:0] req1_a,
   input  logic [p_nbits-1:0] req1_b,
   output logic               resp_val,
   input  logic               resp_rdy,
   output logic [p_nbits-1:0] resp_sum,
   output logic               resp_cout,
   output logic               resp_id
);

   state_t state_q, state_d;
   logic   prio_q, prio_d;
   logic   id_q, id_d;

   logic   idle;
   logic   grant0, grant1;
   logic   fire0, fire1, fire;
   logic   last_bit;
   logic [p_nbits-1:0] a_sel, b_sel;

   assign idle   = (state_q == ST_IDLE);
   assign grant0 = req0_val & (~req1_val | ~prio_q);
   assign grant1 = req1_val & (~req0_val |  prio_q);

   // Gating with reset_n keeps both rdys low while reset is held.
   assign req0_rdy = idle & grant0 & reset_n;
   assign req1_rdy = idle & grant1 & reset_n;
   assign fire0    = req0_val & req0_rdy;
   assign fire1    = req1_val & req1_rdy;
   assign fire     = fire0 | fire1;
   assign a_sel    = fire1 ? req1_a : req0_a;
   assign b_sel    = fire1 ? req1_b : req0_b;

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      id_d    = id_q;
      case (state_q)
         ST_IDLE: begin
            if (fire) begin
               state_d = ST_CALC;
               prio_d  = fire0;
               id_d    = fire1;
            end
         end
         ST_CALC: begin
            if (last_bit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (resp_rdy) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         prio_q  <= 1'b0;
         id_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         id_q    <= id_d;
      end
   end

   serial_adder_dpath #(
      .p_nbits (p_nbits)
   ) u_dpath (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (fire),
      .shift    (state_q == ST_CALC),
      .clear    (fire),
      .a_in     (a_sel),
      .b_in     (b_sel),
      .sum      (resp_sum),
      .cout     (resp_cout),
      .last_bit (last_bit)
   );

   assign resp_val = (state_q == ST_DONE);
   assign resp_id  = id_q;

endmodule

// File: tb/tb_serial_adder_arbiter.sv
// Bench for serial_adder_arbiter: 8- and 16-bit instances share stimulus; one
// is observed at a time against a transaction-level reference model.
module tb_serial_adder_arbiter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        req0_val, req1_val, resp_rdy;
   logic [15:0] a0, b0, a1, b1;

   logic        r0_8, r1_8, rv_8, co_8, id_8;
   logic [7:0]  sum_8;
   logic        r0_16, r1_16, rv_16, co_16, id_16;
   logic [15:0] sum_16;

   serial_adder_arbiter #(.p_nbits(8)) dut8 (
      .clk(clk), .reset_n(reset_n),
      .req0_val(req0_val), .req0_rdy(r0_8), .req0_a(a0[7:0]), .req0_b(b0[7:0]),
      .req1_val(req1_val), .req1_rdy(r1_8), .req1_a(a1[7:0]), .req1_b(b1[7:0]),
      .resp_val(rv_8), .resp_rdy(resp_rdy), .resp_sum(sum_8),
      .resp_cout(co_8), .resp_id(id_8)
   );

   serial_adder_arbiter #(.p_nbits(16)) dut16 (
      .clk(clk), .reset_n(reset_n),
      .req0_val(req0_val), .req0_rdy(r0_16), .req0_a(a0), .req0_b(b0),
      .req1_val(req1_val), .req1_rdy(r1_16), .req1_a(a1), .req1_b(b1),
      .resp_val(rv_16), .resp_rdy(resp_rdy), .resp_sum(sum_16),
      .resp_cout(co_16), .resp_id(id_16)
   );

   logic        sel;
   int          w;
   logic [15:0] mask;

   logic        o_r0, o_r1, o_rv, o_co, o_id;
   logic [15:0] o_sum;
   assign o_r0  = sel ? r0_16 : r0_8;
   assign o_r1  = sel ? r1_16 : r1_8;
   assign o_rv  = sel ? rv_16 : rv_8;
   assign o_co  = sel ? co_16 : co_8;
   assign o_id  = sel ? id_16 : id_8;
   assign o_sum = sel ? sum_16 : {8'h00, sum_8};

   // Reference model: transaction-level view of the block.
   bit          m_idle;
   bit          m_prio;
   int          m_wait;
   logic [15:0] m_sum;
   bit          m_cout;
   bit          m_id;
   bit          acc_ev, acc_id, resp_ev;
   bit          e_g0, e_g1, e_rv;
   int          checks, errors;
   int          obs_ids[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_width(input bit s);
      sel  = s;
      w    = s ? 16 : 8;
      mask = s ? 16'hFFFF : 16'h00FF;
   endtask

   // One clock cycle: check at negedge+1, advance the model at posedge.
   task automatic cycle();
      logic [16:0] x;
      #1;
      e_rv = !m_idle && (m_wait == 0);
      e_g0 = m_idle && req0_val && (!req1_val || !m_prio);
      e_g1 = m_idle && req1_val && (!req0_val ||  m_prio);
      chk("req0_rdy", o_r0, e_g0);
      chk("req1_rdy", o_r1, e_g1);
      chk("resp_val", o_rv, e_rv);
      if (e_rv) begin
         chk("resp_sum", o_sum, m_sum);
         chk("resp_cout", o_co, m_cout);
         chk("resp_id", o_id, m_id);
      end
      @(posedge clk);
      acc_ev  = 0;
      resp_ev = 0;
      if (e_g0 || e_g1) begin
         m_id   = e_g1;
         x      = e_g1 ? ({1'b0, a1 & mask} + {1'b0, b1 & mask})
                       : ({1'b0, a0 & mask} + {1'b0, b0 & mask});
         m_sum  = x[15:0] & mask;
         m_cout = x[w];
         m_prio = !m_id;
         m_idle = 0;
         m_wait = w;
         acc_ev = 1;
         acc_id = m_id;
      end else if (!m_idle && m_wait > 0) begin
         m_wait--;
      end else if (!m_idle && resp_rdy) begin
         m_idle  = 1;
         resp_ev = 1;
         obs_ids.push_back(int'(o_id));
      end
      @(negedge clk);
   endtask

   task automatic bound_fail(input string tag, input int n, input int lim);
      if (n >= lim) begin
         checks++;
         errors++;
         $display("FAIL %s: observed timeout after %0d cycles required event", tag, n);
      end
   endtask

   // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
   task automatic do_reset();
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_resp_val", o_rv, 0);
      chk("rst_resp_sum", o_sum, 0);
      chk("rst_resp_cout", o_co, 0);
      chk("rst_resp_id", o_id, 0);
      chk("rst_req0_rdy", o_r0, 0);
      chk("rst_req1_rdy", o_r1, 0);
      @(negedge clk);
      reset_n = 1'b1;
      m_idle  = 1;
      m_prio  = 0;
      m_wait  = 0;
      acc_ev  = 0;
      resp_ev = 0;
   endtask

   task automatic send(input bit id, input logic [15:0] a, input logic [15:0] b);
      int n;
      if (id) begin req1_val = 1; a1 = a; b1 = b; end
      else    begin req0_val = 1; a0 = a; b0 = b; end
      n = 0;
      do begin cycle(); n++; end while (!acc_ev && n < 100);
      bound_fail("send_accept", n, 100);
      if (id) req1_val = 0; else req0_val = 0;
      n = 0;
      while (!resp_ev && n < 100) begin cycle(); n++; end
      bound_fail("send_resp", n, 100);
   endtask

   initial begin
      int n;
      int done;
      checks   = 0;
      errors   = 0;
      reset_n  = 1'b1;
      req0_val = 1'b1;
      req1_val = 1'b1;
      resp_rdy = 1'b1;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      set_width(0);
      @(negedge clk);
      do_reset();
      req0_val = 0;
      req1_val = 0;

      send(0, 16'h05, 16'h03);
      send(1, 16'hFF, 16'h01);
      send(1, 16'h80, 16'h80);

      // Response stall in DONE with a competing request pending.
      resp_rdy = 0;
      req0_val = 1; a0 = 16'h12; b0 = 16'h34;
      n = 0;
      do begin cycle(); n++; end while (!acc_ev && n < 100);
      req0_val = 0;
      req1_val = 1; a1 = 16'hC3; b1 = 16'h5A;
      n = 0;
      while (!(!m_idle && m_wait == 0) && n < 100) begin cycle(); n++; end
      bound_fail("reach_done", n, 100);
      repeat (5) cycle();
      resp_rdy = 1;
      n = 0;
      do begin cycle(); n++; end while (!acc_ev && n < 100);
      bound_fail("accept_after_done", n, 100);
      req1_val = 0;
      n = 0;
      while (!resp_ev && n < 100) begin cycle(); n++; end

      // Both requesters valid continuously: ids alternate from 0.
      do_reset();
      req0_val = 1; a0 = 16'h21; b0 = 16'h43;
      req1_val = 1; a1 = 16'h99; b1 = 16'h77;
      obs_ids.delete();
      n = 0;
      while (obs_ids.size() < 4 && n < 200) begin cycle(); n++; end
      bound_fail("rr_four", n, 200);
      for (int i = 0; i < obs_ids.size() && i < 4; i++) begin
         chk("rr_order", obs_ids[i], i & 1);
      end
      req0_val = 0;
      req1_val = 0;

      // Reset pulsed mid-calculation; the operation is dropped.
      req0_val = 1; a0 = 16'hAA; b0 = 16'h55;
      n = 0;
      do begin cycle(); n++; end while (!acc_ev && n < 100);
      req0_val = 0;
      repeat (3) cycle();
      req1_val = 1;
      do_reset();
      req1_val = 0;
      repeat (12) cycle();
      send(0, 16'h01, 16'h01);

      // Random traffic at both widths.
      for (int s = 0; s < 2; s++) begin
         set_width(s[0]);
         req0_val = 0;
         req1_val = 0;
         do_reset();
         done = 0;
         n = 0;
         while (done < 500 && n < 30000) begin
            if (acc_ev) begin
               if (acc_id) req1_val = 0; else req0_val = 0;
            end
            if (!req0_val && ($urandom % 3 == 0)) begin
               req0_val = 1; a0 = 16'($urandom); b0 = 16'($urandom);
            end
            if (!req1_val && ($urandom % 3 == 0)) begin
               req1_val = 1; a1 = 16'($urandom); b1 = 16'($urandom);
            end
            resp_rdy = ($urandom % 4) != 0;
            cycle();
            if (resp_ev) done++;
            n++;
         end
         bound_fail("random_run", n, 30000);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_adder_arbiter.md
# serial_adder_arbiter

Controller that shares one bit-serial adder (a single full-adder cell plus a carry flop) between two requesters. It arbitrates round-robin between two latency-insensitive val/rdy request ports and sequences the adder over `p_nbits` cycles. It returns the sum with a requester tag on one val/rdy response port. It sits between the regincr-style register/incrementer stages and the standard-cell datapath, replacing a wide ripple-carry adder with an area-minimal serial one.

## Interface
- `p_nbits`, default 8: operand and sum width; must be ≥ 2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0_val`  in  1  requester 0 has a valid operand pair.
- `req0_rdy`  out  1  the block accepts requester 0 this cycle.
- `req0_a`, `req0_b`  in  `p_nbits` each  requester 0 operands.
- `req1_val`, `req1_rdy`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `resp_val`  out  1  result valid.
- `resp_rdy`  in  1  consumer accepts result.
- `resp_sum`  out  `p_nbits`  (a + b) mod 2^`p_nbits`.
- `resp_cout`  out  1  carry out of the MSB.
- `resp_id`  out  1  index of the requester that issued this result.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - Grant goes to the only valid requester. If both are valid, it goes to the one selected by priority pointer `prio`.
  - `reqN_rdy` = IDLE & grantN. It may depend combinationally on `req*_val`. At most one rdy is high.
  - On a fire (val & rdy):
    - latch a and b into shift registers
    - clear the carry flop to 0
    - clear the bit counter
    - record `resp_id`
    - set `prio` to the other requester
    - go to CALC.
  - With no valid requester, stay in IDLE; `prio` is unchanged.
- **CALC**, once per cycle:
  - Compute s = a[0]^b[0]^c and c' = maj(a[0], b[0], c).
  - Shift a and b right by one.
  - Shift s into the MSB of the sum register, shifting that register right.
  - Update the carry flop with c'.
  - Increment the counter.
  - After the edge that processes bit `p_nbits`-1, go to DONE.
  - Counter width is $clog2(`p_nbits`). It never wraps mid-operation.
- **DONE**
  - `resp_val` = 1.
  - `resp_sum` holds the full sum; `resp_cout` holds the final carry.
  - When `resp_rdy` = 1, go to IDLE. Otherwise hold all response outputs stable.
- Both req rdys are 0 in CALC and DONE. No new request is accepted in the same cycle as a response fires.
- Requester val held low while the other requester waits has no effect. Arbitration is evaluated only in IDLE.

## Timing
- Accept at edge E0.
- CALC occupies the cycles after edges E0..E(`p_nbits`-1).
- `resp_val` rises after edge E`p_nbits`, i.e. `p_nbits`+1 cycles after the accepting cycle.
- Minimum issue interval is `p_nbits`+2 cycles, assuming `resp_rdy` is tied high.
- Reset, asserted at any time including mid-CALC or DONE, takes effect immediately with no clock edge required:
  - state IDLE, `prio` 0, counter 0, carry 0
  - `resp_val` 0, `resp_sum` 0, `resp_cout` 0, `resp_id` 0
  - `req0_rdy`/`req1_rdy` 0 while `reset_n` is low.
- Any in-flight operation is discarded with no response. The first accept can occur in the first cycle after reset_n deasserts.
- No combinational path from `resp_rdy` to any output other than through state.

## Structure
- Package `serial_adder_arbiter_pkg` holds the FSM state enum (IDLE, CALC, DONE).
- Sub-module `serial_adder_dpath` holds:
  - the operand and sum shift registers
  - one full-adder cell
  - the carry flop
  - the bit counter.
- The dpath takes control signals load/shift/clear and reports `last_bit` to the control FSM. Arbitration and the FSM live in the top module.
- All flops use asynchronous active-low reset.

## Test plan
- `p_nbits`=8, only req0 valid, a=0x05, b=0x03, `resp_rdy`=1 → `req0_rdy`=1 in the first IDLE cycle; `resp_val` 9 cycles later with sum 0x08, cout 0, id 0.
- req1 sends a=0xFF, b=0x01 → sum 0x00, cout 1, id 1. Repeat with a=0x80, b=0x80 → sum 0x00, cout 1.
- Both req valid continuously, 4 transactions → ids in order 0,1,0,1. `req0_rdy` and `req1_rdy` are never high together and are 0 in CALC/DONE.
- `resp_rdy` held 0 for 5 cycles in DONE → `resp_val`, sum, cout and id stay stable and no request is accepted. When `resp_rdy` rises, the block returns to IDLE next cycle.
- `reset_n` pulsed low mid-CALC of a=0xAA, b=0x55 → outputs go to reset values immediately and no response appears. The next request (0x01+0x01) returns 0x02 with id 0.
- Random operands, `p_nbits`=8 and 16, random val/rdy stalls, 1000 transactions → every result equals the reference sum and carry, and the ids match the round-robin order.
